// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller for a 4-digit BCD elapsed-time display.
// It prescales the clock into count ticks, keeps a live BCD count and a lap snapshot,
// and drives registered display digits and status flags.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50000,
  parameter bit WRAP     = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap_clear,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       running,
  output logic       lap_active,
  output logic       overflow,
  output logic       tick
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [15:0]   live, live_nxt;
  logic [15:0]   lapr, lapr_nxt;
  logic          ovf_nxt;
  logic          tick_nxt;
  logic          sat;
  logic [16:0]   inc;

  // Add one to a 4-digit BCD value with ripple carry; bit 16 is the carry out of 9999.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  // Next-state, prescaler, count and lap logic.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    live_nxt  = live;
    lapr_nxt  = lapr;
    ovf_nxt   = overflow;
    tick_nxt  = 1'b0;
    sat       = 1'b0;
    inc       = bcd_inc(live);

    // Prescaler and count advance only while the pre-edge state is counting.
    if (state == RUN || state == LAP) begin
      if (presc == PRESC_MAX) begin
        presc_nxt = '0;
        tick_nxt  = 1'b1;
        if (inc[16]) begin
          ovf_nxt = 1'b1;
          if (WRAP) begin
            live_nxt = inc[15:0];
          end else begin
            sat = 1'b1;
          end
        end else begin
          live_nxt = inc[15:0];
        end
      end else begin
        presc_nxt = presc + 1'b1;
      end
    end

    // Button handling; start_stop has priority over lap_clear.
    unique case (state)
      IDLE: begin
        if (start_stop) state_nxt = RUN;
      end
      RUN: begin
        if (start_stop) begin
          state_nxt = PAUSE;
        end else if (lap_clear) begin
          state_nxt = LAP;
          lapr_nxt  = live;
        end
      end
      LAP: begin
        if (start_stop)     state_nxt = PAUSE;
        else if (lap_clear) state_nxt = RUN;
      end
      PAUSE: begin
        if (start_stop)     state_nxt = RUN;
        else if (lap_clear) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Saturating at 9999 stops the watch regardless of any button.
    if (sat) state_nxt = PAUSE;

    // Returning to IDLE starts a fresh measurement.
    if (state_nxt == IDLE && state != IDLE) begin
      live_nxt  = '0;
      presc_nxt = '0;
      ovf_nxt   = 1'b0;
    end
  end

  // State, count, lap snapshot and status flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      presc      <= '0;
      live       <= '0;
      lapr       <= '0;
      overflow   <= 1'b0;
      tick       <= 1'b0;
      running    <= 1'b0;
      lap_active <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      live       <= live_nxt;
      lapr       <= lapr_nxt;
      overflow   <= ovf_nxt;
      tick       <= tick_nxt;
      running    <= (state_nxt == RUN) || (state_nxt == LAP);
      lap_active <= (state_nxt == LAP);
    end
  end

  // Display digits follow the lap snapshot in LAP and the live count otherwise, one cycle late.
  always_ff @(posedge clock) begin
    if (reset) begin
      {d3, d2, d1, d0} <= 16'h0000;
    end else if (state == LAP) begin
      {d3, d2, d1, d0} <= lapr;
    end else begin
      {d3, d2, d1, d0} <= live;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: two instances (saturating and wrapping) share stimulus;
// directed steps push expected outputs tagged with a cycle number, a monitor compares them.
module tb_stopwatch_ctrl;

  logic clock = 1'b0;
  logic reset;
  logic start_stop;
  logic lap_clear;

  logic [3:0] a_d0, a_d1, a_d2, a_d3;
  logic       a_run, a_lap, a_ovf, a_tick;
  logic [3:0] b_d0, b_d1, b_d2, b_d3;
  logic       b_run, b_lap, b_ovf, b_tick;

  always #5 clock = ~clock;

  stopwatch_ctrl #(.TICK_DIV(4), .WRAP(1'b0)) u_sat (
    .clock(clock), .reset(reset), .start_stop(start_stop), .lap_clear(lap_clear),
    .d0(a_d0), .d1(a_d1), .d2(a_d2), .d3(a_d3),
    .running(a_run), .lap_active(a_lap), .overflow(a_ovf), .tick(a_tick)
  );

  stopwatch_ctrl #(.TICK_DIV(4), .WRAP(1'b1)) u_wrap (
    .clock(clock), .reset(reset), .start_stop(start_stop), .lap_clear(lap_clear),
    .d0(b_d0), .d1(b_d1), .d2(b_d2), .d3(b_d3),
    .running(b_run), .lap_active(b_lap), .overflow(b_ovf), .tick(b_tick)
  );

  typedef struct {
    int          cyc;
    int          unit;
    string       name;
    logic [15:0] d;
    logic        run;
    logic        lap;
    logic        ovf;
    logic        tk;
  } exp_t;

  exp_t q[$];
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compare every expectation due in the current cycle against the selected instance.
  always @(negedge clock) begin
    exp_t        e;
    logic [19:0] got;
    logic [19:0] want;
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      e = q.pop_front();
      checks = checks + 1;
      if (e.cyc != cyc_cnt) begin
        errors = errors + 1;
        $display("FAIL %s unit%0d expectation for cycle %0d not checked until cycle %0d",
                 e.name, e.unit, e.cyc, cyc_cnt);
      end else begin
        if (e.unit == 0) got = {a_d3, a_d2, a_d1, a_d0, a_run, a_lap, a_ovf, a_tick};
        else             got = {b_d3, b_d2, b_d1, b_d0, b_run, b_lap, b_ovf, b_tick};
        want = {e.d, e.run, e.lap, e.ovf, e.tk};
        if (got !== want) begin
          errors = errors + 1;
          $display("FAIL %s unit%0d got d=%h run=%b lap=%b ovf=%b tick=%b exp d=%h run=%b lap=%b ovf=%b tick=%b",
                   e.name, e.unit, got[19:4], got[3], got[2], got[1], got[0],
                   e.d, e.run, e.lap, e.ovf, e.tk);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string name, input int unit, input logic [15:0] d,
                            input logic run, input logic lap, input logic ovf, input logic tk);
    exp_t e;
    e.cyc  = cyc_cnt;
    e.unit = unit;
    e.name = name;
    e.d    = d;
    e.run  = run;
    e.lap  = lap;
    e.ovf  = ovf;
    e.tk   = tk;
    q.push_back(e);
  endtask

  task automatic expect_both(input string name, input logic [15:0] d,
                             input logic run, input logic lap, input logic ovf, input logic tk);
    expect_out(name, 0, d, run, lap, ovf, tk);
    expect_out(name, 1, d, run, lap, ovf, tk);
  endtask

  initial begin
    reset = 1'b1; start_stop = 1'b0; lap_clear = 1'b0;
    step(2);
    expect_both("reset_state", 16'h0000, 0, 0, 0, 0);
    reset = 1'b0;
    step(1);
    expect_both("idle_after_reset", 16'h0000, 0, 0, 0, 0);
    lap_clear = 1'b1; step(1); lap_clear = 1'b0;
    expect_both("idle_ignores_lap", 16'h0000, 0, 0, 0, 0);
    step(1);
    expect_both("idle_still", 16'h0000, 0, 0, 0, 0);

    // Start; E0 is the edge that samples start_stop.
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    expect_both("start", 16'h0000, 1, 0, 0, 0);
    for (int k = 1; k <= 40; k++) begin
      step(1);
      expect_both("run_tick_pattern", 16'((k - 1) / 4), 1, 0, 0, (k % 4) == 0);
    end
    step(1);                                              // E41
    expect_both("run_40_cycles", 16'h0010, 1, 0, 0, 0);

    // Lap snapshot at 0012, live keeps counting to 0017.
    step(7);                                              // E48
    lap_clear = 1'b1; step(1); lap_clear = 1'b0;          // E49
    expect_both("lap_enter", 16'h0012, 1, 1, 0, 0);
    step(20);                                             // E69
    expect_both("lap_frozen", 16'h0012, 1, 1, 0, 0);
    lap_clear = 1'b1; step(1); lap_clear = 1'b0;          // E70
    expect_both("lap_exit", 16'h0012, 1, 0, 0, 0);
    step(1);                                              // E71
    expect_both("lap_release_live", 16'h0017, 1, 0, 0, 0);

    // Pause with the prescaler at 2, then resume.
    step(3);                                              // E74
    start_stop = 1'b1; step(1); start_stop = 1'b0;        // E75
    expect_both("pause", 16'h0018, 0, 0, 0, 0);
    step(10);                                             // E85
    expect_both("pause_frozen", 16'h0018, 0, 0, 0, 0);
    start_stop = 1'b1; step(1); start_stop = 1'b0;        // E86
    expect_both("resume", 16'h0018, 1, 0, 0, 0);
    step(1);                                              // E87
    expect_both("resume_tick_next", 16'h0018, 1, 0, 0, 1);
    step(1);                                              // E88
    expect_both("resume_count", 16'h0019, 1, 0, 0, 0);

    // Run to 0123, pause, clear to IDLE, then simultaneous buttons.
    step(415);                                            // E503
    expect_both("reach_123", 16'h0122, 1, 0, 0, 1);
    start_stop = 1'b1; step(1); start_stop = 1'b0;        // E504
    expect_both("pause_123", 16'h0123, 0, 0, 0, 0);
    step(1);
    expect_both("pause_123_hold", 16'h0123, 0, 0, 0, 0);
    lap_clear = 1'b1; step(1); lap_clear = 1'b0;          // E506
    expect_both("clear_to_idle", 16'h0123, 0, 0, 0, 0);
    step(1);                                              // E507
    expect_both("idle_cleared", 16'h0000, 0, 0, 0, 0);
    start_stop = 1'b1; lap_clear = 1'b1; step(1);         // E508
    start_stop = 1'b0; lap_clear = 1'b0;
    expect_both("both_buttons_run", 16'h0000, 1, 0, 0, 0);
    step(4);                                              // E512
    expect_both("fresh_first_tick", 16'h0000, 1, 0, 0, 1);
    step(1);                                              // E513
    expect_both("fresh_count_1", 16'h0001, 1, 0, 0, 0);

    // Reset during LAP at 0456, with button pulses while reset is held.
    step(1819);                                           // E2332
    expect_both("reach_456", 16'h0455, 1, 0, 0, 1);
    lap_clear = 1'b1; step(1); lap_clear = 1'b0;          // E2333
    expect_both("lap_456", 16'h0456, 1, 1, 0, 0);
    step(6);                                              // E2339
    expect_both("lap_456_hold", 16'h0456, 1, 1, 0, 0);
    reset = 1'b1; start_stop = 1'b1; lap_clear = 1'b1; step(1);   // E2340
    expect_both("reset_mid_lap", 16'h0000, 0, 0, 0, 0);
    start_stop = 1'b0; lap_clear = 1'b0; step(1);
    start_stop = 1'b1; step(1);
    start_stop = 1'b0; lap_clear = 1'b1; step(1);
    expect_both("reset_held_buttons", 16'h0000, 0, 0, 0, 0);
    lap_clear = 1'b0; reset = 1'b0; step(1);
    expect_both("reset_release", 16'h0000, 0, 0, 0, 0);
    step(10);
    expect_both("idle_after_reset_pulses", 16'h0000, 0, 0, 0, 0);

    // Run to the top of the range: unit 0 saturates, unit 1 wraps.
    start_stop = 1'b1; step(1); start_stop = 1'b0;        // S
    expect_both("start_long", 16'h0000, 1, 0, 0, 0);
    step(39993);                                          // S+39993
    expect_both("reach_9998", 16'h9998, 1, 0, 0, 0);
    step(4);                                              // S+39997
    expect_both("reach_9999", 16'h9999, 1, 0, 0, 0);
    step(4);                                              // S+40001
    expect_out("sat_overflow", 0, 16'h9999, 0, 0, 1, 0);
    expect_out("wrap_overflow", 1, 16'h0000, 1, 0, 1, 0);
    step(4);                                              // S+40005
    expect_out("sat_stays_paused", 0, 16'h9999, 0, 0, 1, 0);
    expect_out("wrap_keeps_counting", 1, 16'h0001, 1, 0, 1, 0);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
